// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined add/sub/accumulate unit.
// Holds the 2-bit opcode type and its encodings; no logic lives here.
// Imported by pipelined_accum_alu.
package alu_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD = 2'b00;  // result = a + b
  localparam op_t OP_SUB = 2'b01;  // result = a - b, sign-extended
  localparam op_t OP_ACC = 2'b10;  // acc += a + b, result = acc
  localparam op_t OP_CLR = 2'b11;  // acc = 0, result = 0

endpackage

// File: rtl/sat_add.sv
// Accumulator adder: W-bit acc plus W-bit addend, optionally clamped to all-ones.
// Latency: combinational. Backpressure: none, pure datapath.
// Ports: acc_i/add_i operands, sum_o result (clamped when SAT), carry_o raw carry out.
module sat_add #(
  parameter int W   = 16,
  parameter bit SAT = 1'b1
) (
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] add_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o
);

  logic [W:0] total;

  assign total   = {1'b0, acc_i} + {1'b0, add_i};
  assign carry_o = total[W];
  // Carry reports overflow in both modes; only the returned value differs.
  assign sum_o   = (SAT && total[W]) ? {W{1'b1}} : total[W-1:0];

endmodule

// File: rtl/pipelined_accum_alu.sv
// 2-stage pipelined add/sub/accumulate unit with a running accumulator.
// Latency: 2 cycles acceptance -> out_valid, 1 beat/cycle. Backpressure: one global
// stall (!ena or result held unconsumed) freezes both stages; in_ready = !stall.
// Ports: clk, rst_n (async, active low), ena, in_valid/in_ready/op/a/b input beat,
//        out_valid/out_ready/result/overflow output beat.
module pipelined_accum_alu
  import alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  op_t                  op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 overflow
);

  logic stall;

  // Stage 1 state
  logic             s1_vld_q;
  op_t              s1_op_q;
  logic [WIDTH:0]   s1_sum_q;
  logic [WIDTH:0]   s1_diff_q;

  // Stage 2 state
  logic                 out_vld_q;
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic                 overflow_q, overflow_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;

  logic [ACC_WIDTH-1:0] sum_ext;
  logic [ACC_WIDTH-1:0] diff_ext;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic                 acc_carry;

  // No skid buffer: any unconsumed result or disabled clock enable freezes everything.
  assign stall    = !ena || (out_vld_q && !out_ready);
  assign in_ready = !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_op_q   <= OP_ADD;
      s1_sum_q  <= '0;
      s1_diff_q <= '0;
    end else if (!stall) begin
      s1_vld_q <= in_valid;
      if (in_valid) begin
        s1_op_q   <= op;
        s1_sum_q  <= {1'b0, a} + {1'b0, b};
        s1_diff_q <= {1'b0, a} - {1'b0, b};
      end
    end
  end

  // Top bit of diff is the borrow, so a signed cast sign-extends correctly.
  assign sum_ext  = ACC_WIDTH'(s1_sum_q);
  assign diff_ext = ACC_WIDTH'($signed(s1_diff_q));

  sat_add #(
    .W   (ACC_WIDTH),
    .SAT (SATURATE != 0)
  ) u_sat_add (
    .acc_i   (acc_q),
    .add_i   (sum_ext),
    .sum_o   (acc_sum),
    .carry_o (acc_carry)
  );

  always_comb begin
    result_d   = result_q;
    overflow_d = overflow_q;
    acc_d      = acc_q;
    case (s1_op_q)
      OP_ADD: begin
        result_d   = sum_ext;
        overflow_d = s1_sum_q[WIDTH];
      end
      OP_SUB: begin
        result_d   = diff_ext;
        overflow_d = s1_diff_q[WIDTH];
      end
      OP_ACC: begin
        result_d   = acc_sum;
        overflow_d = acc_carry;
        acc_d      = acc_sum;
      end
      OP_CLR: begin
        result_d   = '0;
        overflow_d = 1'b0;
        acc_d      = '0;
      end
      default: ;
    endcase
  end

  // acc is only touched here, so back-to-back ACC beats chain without forwarding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      acc_q      <= '0;
    end else if (!stall) begin
      out_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        result_q   <= result_d;
        overflow_q <= overflow_d;
        acc_q      <= acc_d;
      end
    end
  end

  assign out_valid = out_vld_q;
  assign result    = result_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pipelined_accum_alu.sv
// Bench: three instances (16-bit saturating, 9-bit saturating, 9-bit wrapping) share one
// input stream; a reference model fills a scoreboard queue on acceptance and each
// consumed result is popped and compared, including a 2-cycle latency check.
module tb_pipelined_accum_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       in_valid;
  logic [1:0] op;
  logic [7:0] a, b;
  logic       out_ready;

  logic        in_ready0, in_ready1, in_ready2;
  logic        out_valid0, out_valid1, out_valid2;
  logic [15:0] result0;
  logic [8:0]  result1, result2;
  logic        overflow0, overflow1, overflow2;

  always #5 clk = ~clk;

  pipelined_accum_alu #(.WIDTH(8), .ACC_WIDTH(16), .SATURATE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready0),
    .op(op), .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
    .result(result0), .overflow(overflow0));

  pipelined_accum_alu #(.WIDTH(8), .ACC_WIDTH(9), .SATURATE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready1),
    .op(op), .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .overflow(overflow1));

  pipelined_accum_alu #(.WIDTH(8), .ACC_WIDTH(9), .SATURATE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready2),
    .op(op), .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready),
    .result(result2), .overflow(overflow2));

  typedef struct {
    int unsigned r0, r1, r2;
    bit          o0, o1, o2;
    int          cyc;
    int          st;
  } exp_t;

  exp_t        sb[$];
  int unsigned macc0, macc1, macc2;
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          st_cnt = 0;
  bit          held_vld = 1'b0;
  logic [15:0] held_res;
  bit          rnd_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, accumulator width and saturation as arguments.
  task automatic model(input logic [1:0] o, input int unsigned x, input int unsigned y,
                       input int accw, input bit sat, input int unsigned acc_in,
                       output int unsigned acc_out, output int unsigned r, output bit ov);
    int unsigned m = 32'd1 << accw;
    int unsigned t;
    acc_out = acc_in;
    r = 0;
    ov = 1'b0;
    case (o)
      2'b00: begin r = x + y; ov = (x + y) > 255; end
      2'b01: begin r = (x >= y) ? x - y : m - (y - x); ov = (x < y); end
      2'b10: begin
        t = acc_in + x + y;
        if (t >= m) begin ov = 1'b1; acc_out = sat ? m - 1 : t - m; end
        else acc_out = t;
        r = acc_out;
      end
      default: begin acc_out = 0; r = 0; ov = 1'b0; end
    endcase
  endtask

  // Monitor: acceptance pushes, consumption pops; everything sampled on the falling edge.
  initial begin
    forever begin
      bit   stall_now;
      exp_t e;
      @(negedge clk);
      if (!rst_n) begin
        held_vld = 1'b0;
      end else begin
        cyc++;
        stall_now = !ena || (out_valid0 && !out_ready);
        chk("in_ready", {in_ready0, in_ready1, in_ready2}, stall_now ? 3'b000 : 3'b111);
        if (out_valid0 && stall_now) begin
          if (held_vld) chk("result_held", result0, held_res);
          held_vld = 1'b1;
          held_res = result0;
        end else begin
          held_vld = 1'b0;
        end
        if (!stall_now && out_valid0) begin
          if (sb.size() == 0) begin
            chk("spurious_out", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("result_w16",  result0, e.r0);
            chk("ovf_w16",     overflow0, e.o0);
            chk("result_sat9", result1, e.r1);
            chk("ovf_sat9",    overflow1, e.o1);
            chk("result_wrap9", result2, e.r2);
            chk("ovf_wrap9",   overflow2, e.o2);
            chk("valid_9bit",  {out_valid1, out_valid2}, 2'b11);
            chk("latency", cyc - e.cyc - (st_cnt - e.st), 2);
          end
        end
        if (in_valid && in_ready0) begin
          model(op, a, b, 16, 1'b1, macc0, macc0, e.r0, e.o0);
          model(op, a, b, 9,  1'b1, macc1, macc1, e.r1, e.o1);
          model(op, a, b, 9,  1'b0, macc2, macc2, e.r2, e.o2);
          e.cyc = cyc;
          e.st  = st_cnt;
          sb.push_back(e);
        end
        if (stall_now) st_cnt++;
      end
    end
  end

  task automatic send(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    bit took = 1'b0;
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    for (int i = 0; i < 60 && !took; i++) begin
      @(negedge clk);
      if (in_ready0) took = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!took) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
    op = $urandom_range(0, 3);  // junk while idle must be ignored
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", sb.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    chk({tag, "_out_valid"}, {out_valid0, out_valid1, out_valid2}, 3'b000);
    chk({tag, "_result"}, result0, 0);
    chk({tag, "_overflow"}, overflow0, 0);
    chk({tag, "_in_ready"}, in_ready0, 1);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = 2'b00; a = '0; b = '0;
    macc0 = 0; macc1 = 0; macc2 = 0;
    repeat (2) @(posedge clk);
    check_reset_state("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed add/sub cases
    send(2'b00, 8'd200, 8'd100);
    send(2'b01, 8'd5, 8'd9);
    send(2'b01, 8'd9, 8'd5);
    // Accumulate streaming, then saturation/wrap on the 9-bit instances
    send(2'b11, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++) send(2'b10, 8'd255, 8'd255);
    send(2'b11, 8'd0, 8'd0);
    send(2'b10, 8'd255, 8'd255);
    send(2'b10, 8'd1, 8'd1);
    send(2'b10, 8'd0, 8'd0);   // at all-ones, adding 0 must not flag overflow
    send(2'b00, 8'd255, 8'd0);
    drain();

    // Consumer backpressure with three beats in flight
    out_ready = 1'b0;
    fork
      begin
        send(2'b00, 8'd1, 8'd2);
        send(2'b10, 8'd3, 8'd4);
        send(2'b01, 8'd5, 8'd6);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Clock-enable freeze mid-stream
    fork
      begin
        for (int i = 0; i < 5; i++) send(2'b10, 8'(10 * i), 8'd7);
      end
      begin
        repeat (2) @(posedge clk);
        #1 ena = 1'b0;
        repeat (2) @(posedge clk);
        #1 ena = 1'b1;
      end
    join
    drain();

    // Reset with beats in flight discards them and clears acc
    send(2'b10, 8'd1, 8'd2);
    send(2'b10, 8'd3, 8'd4);
    rst_n = 1'b0;
    sb.delete();
    macc0 = 0; macc1 = 0; macc2 = 0;
    check_reset_state("midreset");
    @(posedge clk); #1 rst_n = 1'b1;
    send(2'b10, 8'd10, 8'd20);
    drain();

    // Random traffic with random stalls
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
          ena       = ($urandom_range(0, 7) != 0);
        end
        out_ready = 1'b1;
        ena = 1'b1;
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
